wb_port_arbiter: RTL and testbench



---
 rtl/wb_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Shares the register-file write port and the commit slot between the
// in-order writeback path (pipe_*) and out-of-order results from the
// multiply/divide unit (mdu_*). The pipe normally has priority. MDU results
// wait in a 2-entry FIFO. A starvation counter forces the FIFO head through
// by stalling the pipe for one cycle.
//
// Ports
//   clk, reset                  clock; synchronous active-low reset
//   pipe_valid/ready            writeback request handshake
//   pipe_pc/wen/dst/data        retiring instruction fields
//   mdu_valid/ready             MDU result handshake (into the FIFO)
//   mdu_pc/dst/data             MDU result fields (always writes)
//   rf_wen/wa/wd                registered register-file write
//   commit_valid/pc/src         registered commit record (src 1 = MDU)
//   fifo_count                  MDU FIFO occupancy, 0..2
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The ready outputs come only from registered state, so they never
// depend on valid in the same cycle. A producer that sees valid && !ready
// holds its fields stable until the transfer.

module wb_port_arbiter #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pipe_valid,
  output logic            pipe_ready,
  input  logic [XLEN-1:0] pipe_pc,
  input  logic            pipe_wen,
  input  logic [4:0]      pipe_dst,
  input  logic [XLEN-1:0] pipe_data,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [XLEN-1:0] mdu_pc,
  input  logic [4:0]      mdu_dst,
  input  logic [XLEN-1:0] mdu_data,
  output logic            rf_wen,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic            commit_src,
  output logic [1:0]      fifo_count
);

  localparam int StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  // FIFO storage, indexed by one-bit read/write pointers.
  logic [XLEN-1:0] fifoPc   [2];
  logic [4:0]      fifoDst  [2];
  logic [XLEN-1:0] fifoData [2];
  logic            wrPtr;
  logic            rdPtr;
  logic [1:0]      count;
  logic [StarveW-1:0] starveCnt;

  logic fifoEmpty;
  logic forceMode;
  logic push;
  logic grantPipe;
  logic grantMdu;

  // Grant decisions use the registered count. An MDU result that arrives
  // this cycle is not visible yet, so it cannot be granted on arrival.
  always_comb begin
    fifoEmpty = (count == 2'd0);
    forceMode = !fifoEmpty && (starveCnt == StarveMax);
    grantPipe = !forceMode && pipe_valid;
    grantMdu  = !fifoEmpty && (forceMode || !pipe_valid);
    push      = mdu_valid && (count < 2'd2);
  end

  assign pipe_ready = !forceMode;
  // A pop in the same cycle does not raise mdu_ready. The slot it frees
  // becomes usable on the next cycle.
  assign mdu_ready  = (count < 2'd2);
  assign fifo_count = count;

  // Payload registers have no reset. Reset clears only the pointers and the
  // count, which discards any entries still held.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoPc[wrPtr]   <= mdu_pc;
      fifoDst[wrPtr]  <= mdu_dst;
      fifoData[wrPtr] <= mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr        <= 1'b0;
      rdPtr        <= 1'b0;
      count        <= 2'd0;
      starveCnt    <= '0;
      rf_wen       <= 1'b0;
      rf_wa        <= 5'd0;
      rf_wd        <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_src   <= 1'b0;
    end else begin
      if (push)     wrPtr <= !wrPtr;
      if (grantMdu) rdPtr <= !rdPtr;

      case ({push, grantMdu})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      // Count the cycles the current head has waited. The count restarts
      // for each new head.
      if (fifoEmpty || grantMdu)
        starveCnt <= '0;
      else if (starveCnt != StarveMax)
        starveCnt <= starveCnt + StarveW'(1);

      commit_valid <= grantPipe || grantMdu;
      if (grantPipe) begin
        rf_wen     <= pipe_wen && (pipe_dst != 5'd0);
        rf_wa      <= pipe_dst;
        rf_wd      <= pipe_data;
        commit_pc  <= pipe_pc;
        commit_src <= 1'b0;
      end else if (grantMdu) begin
        rf_wen     <= (fifoDst[rdPtr] != 5'd0);
        rf_wa      <= fifoDst[rdPtr];
        rf_wd      <= fifoData[rdPtr];
        commit_pc  <= fifoPc[rdPtr];
        commit_src <= 1'b1;
      end else begin
        // No grant this cycle: address, data, PC and src keep their last values.
        rf_wen <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
//
// Bench for wb_port_arbiter with XLEN=64 and STARVE_LIMIT=4.
// - A table of single-cycle pipe vectors is checked directly.
// - Hand-written sequences cover the MDU drain, simultaneous push/pop,
//   starvation, FIFO full, and reset in mid-operation.
// - Each expected commit goes into expQ when its grant is scheduled.
// - A monitor pops expQ on every commit_valid and compares the record.

module tb_wb_port_arbiter;

  localparam int XLEN = 64;
  localparam int EW   = 1 + 1 + 5 + XLEN + XLEN;  // {src, wen, wa, wd, pc}

  logic            clk;
  logic            reset;
  logic            pipe_valid;
  logic            pipe_ready;
  logic [XLEN-1:0] pipe_pc;
  logic            pipe_wen;
  logic [4:0]      pipe_dst;
  logic [XLEN-1:0] pipe_data;
  logic            mdu_valid;
  logic            mdu_ready;
  logic [XLEN-1:0] mdu_pc;
  logic [4:0]      mdu_dst;
  logic [XLEN-1:0] mdu_data;
  logic            rf_wen;
  logic [4:0]      rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic            commit_src;
  logic [1:0]      fifo_count;

  wb_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_pc(pipe_pc),
    .pipe_wen(pipe_wen), .pipe_dst(pipe_dst), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_pc(mdu_pc),
    .mdu_dst(mdu_dst), .mdu_data(mdu_data),
    .rf_wen(rf_wen), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_src(commit_src),
    .fifo_count(fifo_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] expQ[$];   // commits in expected order
  logic [EW-1:0] mduQ[$];   // MDU entries accepted into the FIFO
  logic [EW-1:0] monExp;
  logic [EW-1:0] monGot;
  int nChecks = 0;
  int nFail   = 0;
  string phase = "init";

  // Next pipe / MDU transaction fields.
  logic [XLEN-1:0] pPc, pData, mPc, mData;
  logic [4:0]      pDst, mDst;
  logic            pWen;

  typedef struct packed {
    logic            pv;
    logic [XLEN-1:0] ppc;
    logic            pwen;
    logic [4:0]      pdst;
    logic [XLEN-1:0] pdata;
    logic            expCv;
    logic            expWen;
    logic [4:0]      expWa;
    logic [XLEN-1:0] expWd;
    logic [XLEN-1:0] expPc;
  } vec_t;
  vec_t vecs[7];

  // Expected per-cycle values for the FIFO-full sequence (index = cycle).
  bit ffPr[17]  = '{1,1,1,1,1,0,1,1,1,1,0,1,1,1,1,0,1};
  bit ffMr[17]  = '{1,1,0,0,0,0,1,0,0,0,0,1,1,1,1,1,1};
  int ffCnt[17] = '{0,1,2,2,2,2,1,2,2,2,2,1,1,1,1,1,0};

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    nChecks++;
    if (got !== want) begin
      nFail++;
      $display("FAIL %s/%s: got %0h, expected %0h", phase, name, got, want);
    end
  endtask

  task automatic newPipe();
    pPc   = pPc + 64'd4;
    pDst  = 5'($urandom_range(0, 31));
    pWen  = 1'($urandom_range(0, 1));
    pData = {$urandom, $urandom};
  endtask

  task automatic newMdu();
    mPc   = mPc + 64'd4;
    mDst  = 5'($urandom_range(1, 31));
    mData = {$urandom, $urandom};
  endtask

  // One cycle of sequence stimulus.
  // 1. Check the ready flags and the count against their expected values.
  // 2. Drive the inputs.
  // 3. Schedule the expected commits.
  // 4. Advance one clock.
  task automatic cyc(input bit pv, input bit mv, input bit expPr, input bit expMr,
                     input int expCnt, input bit expMg);
    chk("pipe_ready", pipe_ready, expPr);
    chk("mdu_ready", mdu_ready, expMr);
    chk("fifo_count", fifo_count, expCnt);
    pipe_valid = pv;  pipe_pc = pPc; pipe_wen = pWen; pipe_dst = pDst; pipe_data = pData;
    mdu_valid  = mv;  mdu_pc  = mPc; mdu_dst  = mDst; mdu_data = mData;
    if (mv && expMr) mduQ.push_back({1'b1, mDst != 5'd0, mDst, mData, mPc});
    if (pv && expPr) expQ.push_back({1'b0, pWen && (pDst != 5'd0), pDst, pData, pPc});
    if (expMg && mduQ.size() != 0) expQ.push_back(mduQ.pop_front());
    step();
    if (mv && expMr) newMdu();
    if (pv && expPr) newPipe();
  endtask

  // ---------------- commit monitor ----------------
  always @(negedge clk) begin
    if (commit_valid === 1'b1) begin
      nChecks++;
      monGot = {commit_src, rf_wen, rf_wa, rf_wd, commit_pc};
      if (expQ.size() == 0) begin
        nFail++;
        $display("FAIL %s/commit_unexpected: got pc=%h src=%0d, expected no commit",
                 phase, commit_pc, commit_src);
      end else begin
        monExp = expQ.pop_front();
        if (monGot !== monExp) begin
          nFail++;
          $display("FAIL %s/commit: got {src,wen,wa,wd,pc}=%h, expected %h", phase, monGot, monExp);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    nFail++;
    $display("FAIL watchdog: simulation time limit reached in phase %s", phase);
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

  // ---------------- main test ----------------
  initial begin
    vecs[0] = '{1'b1, 64'h8000_0000, 1'b1, 5'd5,  64'h1234,
                1'b1, 1'b1, 5'd5,  64'h1234, 64'h8000_0000};
    vecs[1] = '{1'b1, 64'h8000_0000, 1'b1, 5'd0,  64'h1234,
                1'b1, 1'b0, 5'd0,  64'h1234, 64'h8000_0000};
    vecs[2] = '{1'b0, 64'hDEAD_BEEF, 1'b1, 5'd9,  64'h55,
                1'b0, 1'b0, 5'd0,  64'h1234, 64'h8000_0000};
    vecs[3] = '{1'b1, 64'h8000_0004, 1'b0, 5'd31, 64'hCAFE,
                1'b1, 1'b0, 5'd31, 64'hCAFE, 64'h8000_0004};
    vecs[4] = '{1'b1, 64'h8000_0008, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF,
                1'b1, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0008};
    vecs[5] = '{1'b0, 64'h0,         1'b1, 5'd3,  64'h77,
                1'b0, 1'b0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0008};
    vecs[6] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 5'd1, 64'h0,
                1'b1, 1'b1, 5'd1,  64'h0, 64'hFFFF_FFFF_FFFF_FFFC};

    pPc = 64'h8000_1000;
    mPc = 64'h4000_0000;
    newPipe();
    newMdu();

    // Reset
    reset = 1'b0; pipe_valid = 1'b0; mdu_valid = 1'b0;
    pipe_pc = '0; pipe_wen = 1'b0; pipe_dst = 5'd0; pipe_data = '0;
    mdu_pc = '0; mdu_dst = 5'd0; mdu_data = '0;
    repeat (3) step();
    phase = "reset";
    chk("rf_wen", rf_wen, 0);
    chk("rf_wa", rf_wa, 0);
    chk("rf_wd", rf_wd, 0);
    chk("commit_valid", commit_valid, 0);
    chk("commit_pc", commit_pc, 0);
    chk("commit_src", commit_src, 0);
    chk("fifo_count", fifo_count, 0);
    chk("pipe_ready", pipe_ready, 1);
    chk("mdu_ready", mdu_ready, 1);
    reset = 1'b1;
    step();

    // Pipe-only vector table
    phase = "table";
    for (int i = 0; i < 7; i++) begin
      chk("pipe_ready", pipe_ready, 1);
      pipe_valid = vecs[i].pv;   pipe_pc   = vecs[i].ppc; pipe_wen = vecs[i].pwen;
      pipe_dst   = vecs[i].pdst; pipe_data = vecs[i].pdata;
      mdu_valid  = 1'b0;
      if (vecs[i].expCv)
        expQ.push_back({1'b0, vecs[i].expWen, vecs[i].expWa, vecs[i].expWd, vecs[i].expPc});
      step();
      chk("commit_valid", commit_valid, vecs[i].expCv);
      chk("rf_wen", rf_wen, vecs[i].expWen);
      chk("rf_wa", rf_wa, vecs[i].expWa);
      chk("rf_wd", rf_wd, vecs[i].expWd);
      chk("commit_pc", commit_pc, vecs[i].expPc);
    end
    pipe_valid = 1'b0;

    // Idle-pipe drain: an MDU result becomes visible two cycles after the push
    phase = "drain";
    mDst = 5'd7; mData = 64'd42;
    cyc(0, 1, 1, 1, 0, 0);
    chk("no_grant_on_arrival", commit_valid, 0);
    cyc(0, 0, 1, 1, 1, 1);
    chk("commit_valid", commit_valid, 1);
    chk("commit_src", commit_src, 1);
    chk("rf_wa", rf_wa, 7);
    chk("rf_wen", rf_wen, 1);
    cyc(0, 0, 1, 1, 0, 0);

    // Simultaneous push and pop: count stays 1 and commits come out in push order.
    // The first entry has dst 0, so its commit must not write the register file.
    phase = "push_pop";
    mDst = 5'd0;
    cyc(0, 1, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 1, 1);
    cyc(0, 0, 1, 1, 1, 1);
    cyc(0, 0, 1, 1, 0, 0);

    // Starvation: one MDU entry waiting behind a continuous pipe stream
    phase = "starve";
    for (int c = 0; c < 10; c++)
      cyc(1, c == 0, c != 5, 1, (c == 0) ? 0 : ((c <= 5) ? 1 : 0), c == 5);

    // FIFO full: the third result waits while mdu_ready is low
    phase = "fifo_full";
    for (int c = 0; c < 17; c++)
      cyc(1, c <= 6, ffPr[c], ffMr[c], ffCnt[c], (c == 5) || (c == 10) || (c == 15));

    // Reset mid-operation with two entries held in the FIFO
    phase = "reset_mid";
    cyc(1, 1, 1, 1, 0, 0);
    cyc(1, 1, 1, 1, 1, 0);
    chk("fifo_count_full", fifo_count, 2);
    chk("mdu_ready_full", mdu_ready, 0);
    reset = 1'b0; pipe_valid = 1'b0; mdu_valid = 1'b0;
    step();
    mduQ.delete();
    chk("rf_wen", rf_wen, 0);
    chk("rf_wa", rf_wa, 0);
    chk("rf_wd", rf_wd, 0);
    chk("commit_valid", commit_valid, 0);
    chk("commit_pc", commit_pc, 0);
    chk("commit_src", commit_src, 0);
    chk("fifo_count", fifo_count, 0);
    reset = 1'b1;
    for (int c = 0; c < 5; c++)
      cyc(0, 0, 1, 1, 0, 0);

    phase = "end";
    chk("expected_commits_left", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
